// File: rtl/param_parking_meter.sv
// Parking meter: coin/preset credit, tick-driven countdown, BCD display with
// low-time blink and idle flash, and a one-cycle expiry pulse.
module param_parking_meter #(
    parameter int TICK_DIV   = 100,
    parameter int FLASH_DIV  = 50,
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 180,
    parameter int COIN0      = 60,
    parameter int COIN1      = 120,
    parameter int COIN2      = 180,
    parameter int COIN3      = 300,
    parameter int PRESET0    = 16,
    parameter int PRESET1    = 150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  coin,
    input  logic [1:0]  preset,
    output logic [13:0] time_val,
    output logic [15:0] digits,
    output logic        disp_on,
    output logic [1:0]  mode,
    output logic        expired
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_LOW  = 2'd2
    } mode_t;

    localparam int          TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          FW      = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [14:0] MAX_T   = 15'(MAX_TIME);
    localparam logic [13:0] LOW_T   = 14'(LOW_THRESH);

    logic [TW-1:0] r_tick_cnt;
    logic [FW-1:0] r_flash_cnt;
    logic          r_flash;
    logic [3:0]    r_coin_q;
    logic [13:0]   r_time;
    mode_t         r_mode;
    logic          r_expired;

    logic          w_tick;
    logic          w_flash_wrap;
    logic [3:0]    w_coin_rise;
    logic [14:0]   w_credit;
    logic [14:0]   w_sum;
    logic [13:0]   w_time_nxt;
    mode_t         w_mode_nxt;
    logic          w_expired_nxt;
    logic          w_disp;

    function automatic mode_t mode_of(input logic [13:0] t);
        if (t == 14'd0)
            return MODE_IDLE;
        else if (t < LOW_T)
            return MODE_LOW;
        else
            return MODE_RUN;
    endfunction

    // Double-dabble binary to 4-digit BCD.
    function automatic logic [15:0] to_bcd(input logic [13:0] bin);
        logic [29:0] sh;
        sh = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[14+4*d +: 4] >= 4'd5)
                    sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        return sh[29:14];
    endfunction

    assign w_tick       = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_flash_wrap = (r_flash_cnt == FW'(FLASH_DIV - 1));
    assign w_coin_rise  = coin & ~r_coin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_flash_cnt <= '0;
            r_flash     <= 1'b1;
            r_coin_q    <= 4'd0;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_flash_cnt <= w_flash_wrap ? '0 : r_flash_cnt + FW'(1);
            r_flash     <= w_flash_wrap ? ~r_flash : r_flash;
            r_coin_q    <= coin;
        end
    end

    // Lowest-index coin wins; simultaneous higher coins are dropped.
    always_comb begin
        w_credit = 15'd0;
        if (w_coin_rise[0])
            w_credit = 15'(COIN0);
        else if (w_coin_rise[1])
            w_credit = 15'(COIN1);
        else if (w_coin_rise[2])
            w_credit = 15'(COIN2);
        else if (w_coin_rise[3])
            w_credit = 15'(COIN3);
    end

    assign w_sum = {1'b0, r_time} + w_credit - 15'(w_tick);

    always_comb begin
        w_time_nxt    = r_time;
        w_expired_nxt = 1'b0;
        if (preset[0]) begin
            w_time_nxt = 14'(PRESET0);
        end else if (preset[1]) begin
            w_time_nxt = 14'(PRESET1);
        end else if (|w_coin_rise) begin
            w_time_nxt = (w_sum > MAX_T) ? MAX_T[13:0] : w_sum[13:0];
        end else if (w_tick && (r_time != 14'd0)) begin
            w_time_nxt    = r_time - 14'd1;
            w_expired_nxt = (r_time == 14'd1);
        end
        w_mode_nxt = mode_of(w_time_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_time    <= 14'd0;
            r_mode    <= MODE_IDLE;
            r_expired <= 1'b0;
        end else begin
            r_time    <= w_time_nxt;
            r_mode    <= w_mode_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    // Low time blinks on the parity of the remaining time.
    always_comb begin
        w_disp = 1'b1;
        case (r_mode)
            MODE_IDLE: w_disp = r_flash;
            MODE_LOW:  w_disp = ~r_time[0];
            default:   w_disp = 1'b1;
        endcase
    end

    assign time_val = r_time;
    assign mode     = r_mode;
    assign expired  = r_expired;
    assign disp_on  = w_disp;
    assign digits   = to_bcd(r_time);

endmodule

// File: tb/tb_param_parking_meter.sv
// Scoreboard bench for param_parking_meter: directed scenarios plus random
// coin/preset/reset traffic against an arithmetic reference model.
module tb_param_parking_meter;

    localparam int TICK_DIV   = 100;
    localparam int FLASH_DIV  = 50;
    localparam int MAX_TIME   = 9999;
    localparam int LOW_THRESH = 180;
    localparam int PRESET0    = 16;
    localparam int PRESET1    = 150;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  coin = 4'd0;
    logic [1:0]  preset = 2'd0;
    logic [13:0] time_val;
    logic [15:0] digits;
    logic        disp_on;
    logic [1:0]  mode;
    logic        expired;

    always #5 clk = ~clk;

    param_parking_meter #(
        .TICK_DIV(TICK_DIV), .FLASH_DIV(FLASH_DIV), .MAX_TIME(MAX_TIME),
        .LOW_THRESH(LOW_THRESH), .COIN0(60), .COIN1(120), .COIN2(180),
        .COIN3(300), .PRESET0(PRESET0), .PRESET1(PRESET1)
    ) dut (
        .clk(clk), .rst(rst), .coin(coin), .preset(preset),
        .time_val(time_val), .digits(digits), .disp_on(disp_on),
        .mode(mode), .expired(expired)
    );

    typedef struct {
        int t;
        int dig;
        int md;
        int dsp;
        int ex;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int       coin_val[4] = '{60, 120, 180, 300};
    int       m_time = 0;
    int       m_k = 0;
    int       m_exp = 0;
    bit [3:0] m_coin_prev = 4'd0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    // One clock: drive inputs, advance the model across the coming edge,
    // queue what the outputs must show after that edge.
    task automatic step(input bit [3:0] c, input bit [1:0] p, input bit r);
        exp_t    e;
        bit      tick;
        bit [3:0] rise;
        int      sel;
        @(negedge clk);
        coin = c;
        preset = p;
        rst = r;
        if (r) begin
            m_time = 0;
            m_k = 0;
            m_exp = 0;
            m_coin_prev = 4'd0;
        end else begin
            tick = ((m_k % TICK_DIV) == TICK_DIV - 1);
            rise = c & ~m_coin_prev;
            m_exp = 0;
            sel = -1;
            for (int i = 3; i >= 0; i--)
                if (rise[i]) sel = i;
            if (p[0])
                m_time = PRESET0;
            else if (p[1])
                m_time = PRESET1;
            else if (sel >= 0) begin
                m_time = m_time + coin_val[sel] - (tick ? 1 : 0);
                if (m_time > MAX_TIME) m_time = MAX_TIME;
            end else if (tick && m_time > 0) begin
                if (m_time == 1) m_exp = 1;
                m_time = m_time - 1;
            end
            m_coin_prev = c;
            m_k++;
        end
        e.t   = m_time;
        e.dig = ((m_time / 1000) << 12) | (((m_time / 100) % 10) << 8)
              | (((m_time / 10) % 10) << 4) | (m_time % 10);
        e.md  = (m_time == 0) ? 0 : (m_time < LOW_THRESH) ? 2 : 1;
        if (e.md == 0)
            e.dsp = (((m_k / FLASH_DIV) % 2) == 0) ? 1 : 0;
        else if (e.md == 1)
            e.dsp = 1;
        else
            e.dsp = ((m_time % 2) == 0) ? 1 : 0;
        e.ex  = m_exp;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 2'd0, 1'b0);
    endtask

    // Idle until the next cycle is a tick cycle with the given time remaining.
    task automatic align_tick(input int target);
        bit found;
        found = 0;
        for (int n = 0; n < 5000 && !found; n++) begin
            if (m_time == target && (m_k % TICK_DIV) == TICK_DIV - 1)
                found = 1;
            else
                step(4'd0, 2'd0, 1'b0);
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL align_timeout: got time %0d, expected %0d", m_time, target);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("time_val", int'(time_val), e.t);
                chk("digits",   int'(digits),   e.dig);
                chk("mode",     int'(mode),     e.md);
                chk("disp_on",  int'(disp_on),  e.dsp);
                chk("expired",  int'(expired),  e.ex);
            end
        end
    end

    initial begin : driver
        bit [3:0] c;
        bit [1:0] p;
        bit       r;

        step(4'd0, 2'd0, 1'b1);
        step(4'd0, 2'd0, 1'b1);

        // Held coin[0]: one credit only, then countdown.
        for (int i = 0; i < 300; i++) step(4'b0001, 2'd0, 1'b0);
        idle(3);

        // Preset[1] and low-time blink.
        step(4'd0, 2'd0, 1'b1);
        step(4'd0, 2'b10, 1'b0);
        idle(250);

        // Saturation at MAX_TIME.
        step(4'd0, 2'd0, 1'b1);
        for (int i = 0; i < 34; i++) begin
            step(4'b1000, 2'd0, 1'b0);
            step(4'b0000, 2'd0, 1'b0);
        end
        step(4'b0001, 2'd0, 1'b0);
        idle(2);

        // Preset[0] down to expiry, then idle flash.
        step(4'd0, 2'b01, 1'b0);
        idle(16 * TICK_DIV + 3 * FLASH_DIV);

        // Coin coincident with tick at 100, then simultaneous coin[1]/coin[2].
        step(4'd0, 2'd0, 1'b1);
        step(4'b0010, 2'd0, 1'b0);
        idle(1);
        align_tick(100);
        step(4'b0001, 2'd0, 1'b0);
        idle(1);
        step(4'b0110, 2'd0, 1'b0);
        idle(2);

        // Reset mid-count, and coin held across reset release.
        step(4'd0, 2'd0, 1'b1);
        step(4'b1000, 2'd0, 1'b0);
        idle(1);
        step(4'b0100, 2'd0, 1'b0);
        idle(1);
        step(4'b0001, 2'd0, 1'b0);
        idle(57);
        step(4'b0100, 2'd0, 1'b1);
        step(4'b0100, 2'd0, 1'b1);
        step(4'b0100, 2'd0, 1'b0);
        idle(TICK_DIV + 5);

        // Random traffic.
        c = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                c = c ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                c = 4'($urandom_range(0, 15));
            p = ($urandom_range(0, 99) < 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            r = ($urandom_range(0, 999) < 3);
            step(c, p, r);
        end
        idle(2);

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
